// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I, read-only)
// and execute load/store (D). One transaction is outstanding at a time. D has
// priority, but after STARVE_LIMIT consecutive D grants against a waiting fetch
// the fetch is forced through. A fetch flush kills the response of an in-flight fetch.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // Fetch port
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rdata,
  input  logic        i_flush,
  // Load/store port
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_write,
  input  logic [1:0]  d_width,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  // Memory port
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_write,
  output logic [1:0]  m_width,
  input  logic        m_rsp_valid,
  input  logic [31:0] m_rdata,
  // Status
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
  localparam logic [1:0] FetchWidth = 2'b10;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  typedef enum logic {OwnI = 1'b0, OwnD = 1'b1} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        kill_q, kill_d;
  logic [3:0]  starve_q, starve_d;
  logic        err_q, err_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        m_write_q, m_write_d;
  logic [1:0]  m_width_q, m_width_d;

  logic grant_i, grant_d;
  logic accept_i, accept_d;
  logic rsp_done;

  // Arbitration: D wins ties unless the fetch has been starved to the limit.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (i_req_valid && d_req_valid) begin
      if (starve_q == StarveMax) begin
        grant_i = 1'b1;
      end else begin
        grant_d = 1'b1;
      end
    end else begin
      grant_i = i_req_valid;
      grant_d = d_req_valid;
    end
    accept_i = (state_q == StIdle) && grant_i;
    accept_d = (state_q == StIdle) && grant_d;
    rsp_done = (state_q == StWait) && m_rsp_valid;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> ISSUE on accept, ISSUE -> WAIT on handshake, WAIT -> IDLE on response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept_i || accept_d) state_d = StIssue;
      StIssue: if (m_req_ready) state_d = StWait;
      StWait:  if (m_rsp_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; readys are forced low while reset is held.
  always_comb begin
    i_req_ready = accept_i && !rst;
    d_req_ready = accept_d && !rst;
    m_req_valid = (state_q == StIssue);
    busy        = (state_q != StIdle);
    // A flush in the response cycle suppresses the fetch response as well.
    i_rsp_valid = rsp_done && (owner_q == OwnI) && !kill_q && !i_flush;
    d_rsp_valid = rsp_done && (owner_q == OwnD);
    i_rdata     = m_rdata;
    d_rdata     = m_rdata;
  end

  // Transaction capture, starvation count, kill flag and error flag next-state.
  always_comb begin
    owner_d   = owner_q;
    kill_d    = kill_q;
    starve_d  = starve_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_write_d = m_write_q;
    m_width_d = m_width_q;
    err_d     = err_q || (m_rsp_valid && (state_q != StWait));

    if (accept_i) begin
      owner_d   = OwnI;
      m_addr_d  = i_addr;
      m_wdata_d = 32'h0;
      m_write_d = 1'b0;
      m_width_d = FetchWidth;
      starve_d  = 4'd0;
      kill_d    = i_flush;
    end else if (accept_d) begin
      owner_d   = OwnD;
      m_addr_d  = d_addr;
      m_wdata_d = d_wdata;
      m_write_d = d_write;
      m_width_d = d_width;
      kill_d    = 1'b0;
      if (i_req_valid && (starve_q < StarveMax)) begin
        starve_d = starve_q + 4'd1;
      end
    end else if (state_q != StIdle) begin
      if (rsp_done) begin
        kill_d = 1'b0;
      end else if (i_flush && (owner_q == OwnI)) begin
        kill_d = 1'b1;
      end
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= OwnI;
      kill_q    <= 1'b0;
      starve_q  <= 4'd0;
      err_q     <= 1'b0;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      m_write_q <= 1'b0;
      m_width_q <= 2'b00;
    end else begin
      owner_q   <= owner_d;
      kill_q    <= kill_d;
      starve_q  <= starve_d;
      err_q     <= err_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_write_q <= m_write_d;
      m_width_q <= m_width_d;
    end
  end

  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_write = m_write_q;
  assign m_width = m_width_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_flush;
  logic [31:0] i_addr, i_rdata;
  logic        d_req_valid, d_req_ready, d_write, d_rsp_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_width;
  logic        m_req_valid, m_req_ready, m_write, m_rsp_valid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_width;
  logic        busy, err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata), .i_flush(i_flush),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_write(d_write), .d_width(d_width),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_write(m_write), .m_width(m_width),
    .m_rsp_valid(m_rsp_valid), .m_rdata(m_rdata),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req_valid = 0; i_addr = 0; i_flush = 0;
    d_req_valid = 0; d_addr = 0; d_wdata = 0; d_write = 0; d_width = 0;
    m_req_ready = 0; m_rsp_valid = 0; m_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    i_req_valid = 1; d_req_valid = 1;
    @(negedge clk);
    checks++; if (i_req_ready !== 1'b0) begin errors++; $display("FAIL rst_i_ready got %b exp 0", i_req_ready); end
    checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready got %b exp 0", d_req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (m_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got %b exp 0", m_req_valid); end
    checks++; if ({m_addr, m_wdata, m_write, m_width} !== 67'h0) begin
      errors++; $display("FAIL rst_mfields got %h %h %b %b exp 0", m_addr, m_wdata, m_write, m_width);
    end
    checks++; if ({err, i_rsp_valid, d_rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b%b%b exp 000", err, i_rsp_valid, d_rsp_valid);
    end
    do_reset();
  endtask

  task automatic test_fetch();
    do_reset();
    i_req_valid = 1; i_addr = 32'h100;
    @(negedge clk);
    checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready got %b exp 1", i_req_ready); end
    checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL fetch_dready got %b exp 0", d_req_ready); end
    tick();
    i_req_valid = 0; i_addr = 32'hFFFF_FFFF; m_req_ready = 1;
    @(negedge clk);
    checks++; if (m_req_valid !== 1'b1) begin errors++; $display("FAIL fetch_mvalid got %b exp 1", m_req_valid); end
    checks++; if ({m_addr, m_wdata, m_write, m_width} !== {32'h100, 32'h0, 1'b0, 2'b10}) begin
      errors++; $display("FAIL fetch_mfields got %h %h %b %b exp 100 0 0 10", m_addr, m_wdata, m_write, m_width);
    end
    tick();
    m_req_ready = 0; m_rsp_valid = 1; m_rdata = 32'h0050_0093;
    @(negedge clk);
    checks++; if (i_rsp_valid !== 1'b1) begin errors++; $display("FAIL fetch_rsp got %b exp 1", i_rsp_valid); end
    checks++; if (i_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_rdata got %h exp 00500093", i_rdata); end
    checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_drsp got %b exp 0", d_rsp_valid); end
    tick();
    m_rsp_valid = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_busy got %b exp 0", busy); end
    checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_rsp_end got %b exp 0", i_rsp_valid); end
  endtask

  task automatic test_store_stall();
    int pulses;
    do_reset();
    d_req_valid = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_write = 1; d_width = 2'd2;
    @(negedge clk);
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL store_ready got %b exp 1", d_req_ready); end
    tick();
    d_req_valid = 0; d_addr = 32'h0; d_wdata = 32'h0; d_write = 0; d_width = 0;
    for (int c = 0; c < 4; c++) begin
      m_req_ready = (c == 3);
      @(negedge clk);
      checks++; if (m_req_valid !== 1'b1) begin errors++; $display("FAIL store_mvalid got %b exp 1", m_req_valid); end
      checks++; if ({m_addr, m_wdata, m_write, m_width} !== {32'h2000, 32'hDEAD_BEEF, 1'b1, 2'd2}) begin
        errors++; $display("FAIL store_mfields got %h %h %b %b exp 2000 deadbeef 1 10", m_addr, m_wdata, m_write, m_width);
      end
      checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL store_early_rsp got %b exp 0", d_rsp_valid); end
      tick();
    end
    m_req_ready = 0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      m_rsp_valid = (c == 0);
      @(negedge clk);
      if (d_rsp_valid === 1'b1) pulses++;
      tick();
    end
    m_rsp_valid = 0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL store_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_starve();
    bit got_d[$];
    bit rsp_next;
    do_reset();
    i_req_valid = 1; i_addr = 32'h40; d_req_valid = 1; d_addr = 32'h80; d_write = 0;
    m_req_ready = 1; rsp_next = 0;
    for (int c = 0; c < 45; c++) begin
      m_rsp_valid = rsp_next;
      @(negedge clk);
      if (d_req_ready === 1'b1) got_d.push_back(1'b1);
      else if (i_req_ready === 1'b1) got_d.push_back(1'b0);
      rsp_next = (m_req_valid === 1'b1);
      tick();
    end
    i_req_valid = 0; d_req_valid = 0; m_rsp_valid = 0; m_req_ready = 0;
    checks++; if (got_d.size() < 10) begin errors++; $display("FAIL starve_count got %0d exp >=10", got_d.size()); end
    for (int k = 0; k < 10; k++) begin
      bit exp_d;
      exp_d = ((k % (Limit + 1)) != Limit);
      if (k < got_d.size()) begin
        checks++; if (got_d[k] !== exp_d) begin
          errors++; $display("FAIL starve_grant%0d got %s exp %s", k, got_d[k] ? "D" : "I", exp_d ? "D" : "I");
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    i_req_valid = 1; i_addr = 32'h200;
    @(negedge clk);
    checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL flush_iready got %b exp 1", i_req_ready); end
    tick();
    i_req_valid = 0; m_req_ready = 1;
    @(negedge clk);
    checks++; if (m_req_valid !== 1'b1) begin errors++; $display("FAIL flush_mvalid got %b exp 1", m_req_valid); end
    tick();
    m_req_ready = 0; i_flush = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy got %b exp 1", busy); end
    tick();
    i_flush = 0; m_rsp_valid = 1; m_rdata = 32'h1234_5678;
    d_req_valid = 1; d_addr = 32'h300; d_write = 0; d_width = 2'd2;
    @(negedge clk);
    checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_killed_rsp got %b exp 0", i_rsp_valid); end
    checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_drsp got %b exp 0", d_rsp_valid); end
    checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL flush_dready_wait got %b exp 0", d_req_ready); end
    tick();
    m_rsp_valid = 0;
    @(negedge clk);
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL flush_dready got %b exp 1", d_req_ready); end
    tick();
    d_req_valid = 0; m_req_ready = 1;
    @(negedge clk);
    checks++; if (m_addr !== 32'h300) begin errors++; $display("FAIL flush_daddr got %h exp 300", m_addr); end
    tick();
    m_req_ready = 0; m_rsp_valid = 1;
    @(negedge clk);
    checks++; if (d_rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_drsp_ok got %b exp 1", d_rsp_valid); end
    tick();
    m_rsp_valid = 0;
  endtask

  task automatic test_spurious();
    do_reset();
    m_rsp_valid = 1; m_rdata = 32'hABCD;
    @(negedge clk);
    checks++; if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL spur_rsp got %b%b exp 00", i_rsp_valid, d_rsp_valid);
    end
    tick();
    m_rsp_valid = 0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err got %b exp 1", err); end
    repeat (5) tick();
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err_sticky got %b exp 1", err); end
    tick();
    do_reset();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL spur_err_clr got %b exp 0", err); end
    tick();
  endtask

  task automatic test_rst_mid();
    do_reset();
    d_req_valid = 1; d_addr = 32'h400; d_write = 0; d_width = 2'b01;
    @(negedge clk);
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", d_req_ready); end
    tick();
    d_req_valid = 0; m_req_ready = 1;
    @(negedge clk);
    tick();
    m_req_ready = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_wait got %b exp 1", busy); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({busy, m_req_valid, d_rsp_valid, err} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_flags got %b%b%b%b exp 0000", busy, m_req_valid, d_rsp_valid, err);
    end
    checks++; if ({m_addr, m_width} !== 34'h0) begin
      errors++; $display("FAIL rstmid_mfields got %h %b exp 0", m_addr, m_width);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    m_rsp_valid = 1;
    @(negedge clk);
    checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_late_rsp got %b exp 0", d_rsp_valid); end
    tick();
    m_rsp_valid = 0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rstmid_err got %b exp 1", err); end
    tick();
  endtask

  // Randomized run against a transaction-level model of the arbitration rules.
  task automatic test_random();
    bit pi_v, pd_v;
    logic [31:0] pi_addr, pd_addr, pd_wdata;
    bit pd_write;
    logic [1:0] pd_width;
    bit idle, t_own_d, t_issued, t_killed;
    logic [31:0] t_addr, t_wdata;
    bit t_write;
    logic [1:0] t_width;
    int starve, rsp_wait;
    bit eg_i, eg_d, exp_mv, exp_irsp, exp_drsp;
    do_reset();
    pi_v = 0; pd_v = 0; idle = 1; starve = 0; rsp_wait = 0;
    t_own_d = 0; t_issued = 0; t_killed = 0;
    t_addr = 0; t_wdata = 0; t_write = 0; t_width = 0;
    pi_addr = 0; pd_addr = 0; pd_wdata = 0; pd_write = 0; pd_width = 0;
    for (int c = 0; c < 600; c++) begin
      if (!pi_v && $urandom_range(0, 99) < 45) begin
        pi_v = 1; pi_addr = $urandom;
      end
      if (!pd_v && $urandom_range(0, 99) < 45) begin
        pd_v = 1; pd_addr = $urandom; pd_wdata = $urandom;
        pd_write = 1'($urandom_range(0, 1)); pd_width = 2'($urandom_range(0, 3));
      end
      i_req_valid = pi_v; i_addr = pi_addr;
      d_req_valid = pd_v; d_addr = pd_addr; d_wdata = pd_wdata; d_write = pd_write; d_width = pd_width;
      i_flush = ($urandom_range(0, 99) < 10);
      m_req_ready = 1'($urandom_range(0, 1));
      m_rsp_valid = !idle && t_issued && (rsp_wait == 0);
      m_rdata = $urandom;

      eg_i = 0; eg_d = 0;
      if (idle) begin
        if (pi_v && pd_v) begin
          if (starve == Limit) eg_i = 1; else eg_d = 1;
        end else begin
          eg_i = pi_v; eg_d = pd_v;
        end
      end
      exp_mv   = !idle && !t_issued;
      exp_irsp = m_rsp_valid && !t_own_d && !t_killed && !i_flush;
      exp_drsp = m_rsp_valid && t_own_d;

      @(negedge clk);
      checks++; if (i_req_ready !== eg_i) begin errors++; $display("FAIL rnd_iready c%0d got %b exp %b", c, i_req_ready, eg_i); end
      checks++; if (d_req_ready !== eg_d) begin errors++; $display("FAIL rnd_dready c%0d got %b exp %b", c, d_req_ready, eg_d); end
      checks++; if (busy !== !idle) begin errors++; $display("FAIL rnd_busy c%0d got %b exp %b", c, busy, !idle); end
      checks++; if (m_req_valid !== exp_mv) begin errors++; $display("FAIL rnd_mvalid c%0d got %b exp %b", c, m_req_valid, exp_mv); end
      if (exp_mv) begin
        checks++; if ({m_addr, m_wdata, m_write, m_width} !== {t_addr, t_wdata, t_write, t_width}) begin
          errors++; $display("FAIL rnd_mfields c%0d got %h %h %b %b exp %h %h %b %b", c,
                             m_addr, m_wdata, m_write, m_width, t_addr, t_wdata, t_write, t_width);
        end
      end
      checks++; if (i_rsp_valid !== exp_irsp) begin errors++; $display("FAIL rnd_irsp c%0d got %b exp %b", c, i_rsp_valid, exp_irsp); end
      checks++; if (d_rsp_valid !== exp_drsp) begin errors++; $display("FAIL rnd_drsp c%0d got %b exp %b", c, d_rsp_valid, exp_drsp); end
      checks++; if ({i_rdata, d_rdata} !== {m_rdata, m_rdata}) begin
        errors++; $display("FAIL rnd_rdata c%0d got %h %h exp %h", c, i_rdata, d_rdata, m_rdata);
      end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err c%0d got %b exp 0", c, err); end

      if (idle) begin
        if (eg_i) begin
          t_own_d = 0; t_addr = pi_addr; t_wdata = 0; t_write = 0; t_width = 2'b10;
          t_killed = i_flush; starve = 0; pi_v = 0;
          idle = 0; t_issued = 0;
        end else if (eg_d) begin
          t_own_d = 1; t_addr = pd_addr; t_wdata = pd_wdata; t_write = pd_write; t_width = pd_width;
          t_killed = 0; pd_v = 0;
          if (pi_v) starve = (starve + 1 > Limit) ? Limit : starve + 1;
          idle = 0; t_issued = 0;
        end
      end else begin
        if (!t_own_d && i_flush) t_killed = 1;
        if (!t_issued) begin
          if (m_req_ready) begin
            t_issued = 1; rsp_wait = $urandom_range(0, 2);
          end
        end else if (m_rsp_valid) begin
          idle = 1;
        end else begin
          rsp_wait--;
        end
      end
      tick();
    end
    i_req_valid = 0; d_req_valid = 0; i_flush = 0; m_req_ready = 0; m_rsp_valid = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_stall();
    test_starve();
    test_flush();
    test_spurious();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
